// File: rtl/ov5642_pkg.sv
// ov5642_pkg: state encodings, output decode and default timing for the OV5642 power sequencer
package ov5642_pkg;

    localparam int CLK_HZ     = 100_000_000;
    localparam int T_LOCK_DEF = 2_000_000;
    localparam int T_XCLK_DEF = 10_000;
    localparam int T_PWDN_DEF = 500_000;
    localparam int T_SCCB_DEF = 2_000_000;

    typedef enum logic [2:0] {
        IDLE, WAIT_LOCK, XCLK_ON, PWDN_WAIT, SCCB_WAIT, DONE, FAULT, STANDBY
    } state_t;

    typedef struct packed {
        logic xclk_en;
        logic cam_pwdn;
        logic cam_resetb;
        logic seq_done;
        logic busy;
        logic fault;
    } outs_t;

    // Output pattern owned by each state; registered on the edge the state is entered
    function automatic outs_t decode(state_t s);
        outs_t o;
        o.xclk_en    = s inside {XCLK_ON, PWDN_WAIT, SCCB_WAIT, DONE, STANDBY};
        o.cam_pwdn   = !(s inside {PWDN_WAIT, SCCB_WAIT, DONE});
        o.cam_resetb = s inside {SCCB_WAIT, DONE, STANDBY};
        o.seq_done   = s == DONE;
        o.busy       = s inside {WAIT_LOCK, XCLK_ON, PWDN_WAIT, SCCB_WAIT};
        o.fault      = s == FAULT;
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async level through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ov5642_power_seq.sv
// ov5642_power_seq: OV5642 power-up/reset sequencer; OV_STANDBY_EN adds a standby input and state
module ov5642_power_seq
    import ov5642_pkg::*;
#(
    parameter int T_LOCK_CYC = T_LOCK_DEF,
    parameter int T_XCLK_CYC = T_XCLK_DEF,
    parameter int T_PWDN_CYC = T_PWDN_DEF,
    parameter int T_SCCB_CYC = T_SCCB_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic dcm_locked,
    input  logic start,
`ifdef OV_STANDBY_EN
    input  logic standby,
`endif
    output logic xclk_en,
    output logic cam_pwdn,
    output logic cam_resetb,
    output logic seq_done,
    output logic busy,
    output logic fault
);

    localparam int T_A   = (T_LOCK_CYC > T_XCLK_CYC) ? T_LOCK_CYC : T_XCLK_CYC;
    localparam int T_B   = (T_PWDN_CYC > T_SCCB_CYC) ? T_PWDN_CYC : T_SCCB_CYC;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lock_s;
    outs_t         o;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (dcm_locked),
        .q   (lock_s)
    );

    assign {xclk_en, cam_pwdn, cam_resetb, seq_done, busy, fault} = o;

    // Next state and dwell counter; lock loss outranks start, start outranks timer expiry
    always_comb begin
        state_n = state;
        cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
        case (state)
            IDLE:
                if (start) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = CW'(T_LOCK_CYC - 1);
                end
            WAIT_LOCK:
                if (lock_s) begin
                    state_n = XCLK_ON;
                    cnt_n   = CW'(T_XCLK_CYC - 1);
                end else if (cnt == '0) state_n = FAULT;
            XCLK_ON:
                if (!lock_s) state_n = FAULT;
                else if (cnt == '0) begin
                    state_n = PWDN_WAIT;
                    cnt_n   = CW'(T_PWDN_CYC - 1);
                end
            PWDN_WAIT:
                if (!lock_s) state_n = FAULT;
                else if (cnt == '0) begin
                    state_n = SCCB_WAIT;
                    cnt_n   = CW'(T_SCCB_CYC - 1);
                end
            SCCB_WAIT:
                if (!lock_s) state_n = FAULT;
                else if (cnt == '0) state_n = DONE;
            DONE:
                if (!lock_s) state_n = FAULT;
                else if (start) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = CW'(T_LOCK_CYC - 1);
                end
`ifdef OV_STANDBY_EN
                else if (standby) state_n = STANDBY;
            STANDBY:
                if (!lock_s) state_n = FAULT;
                else if (!standby) begin
                    state_n = SCCB_WAIT;
                    cnt_n   = CW'(T_SCCB_CYC - 1);
                end
`endif
            FAULT:
                if (start) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = CW'(T_LOCK_CYC - 1);
                end
            default: state_n = IDLE;
        endcase
    end

    // State, counter and outputs all update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            o     <= decode(IDLE);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            o     <= decode(state_n);
        end
    end

endmodule
